// File: rtl/fp_add_arbiter.sv
// Round-robin scheduler sharing one bfloat16 adder among NUM_REQ requesters.
// Tracks in-flight ops with a LAT-deep tag pipeline and returns each sum to its issuer.
module fp_add_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int LAT     = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [16*NUM_REQ-1:0]  req_opA,
  input  logic [16*NUM_REQ-1:0]  req_opB,
  output logic [NUM_REQ-1:0]     resp_valid,
  input  logic [NUM_REQ-1:0]     resp_ready,
  output logic [19*NUM_REQ-1:0]  resp_data,
  output logic [15:0]            add_opA,
  output logic [15:0]            add_opB,
  output logic                   add_issue,
  input  logic [15:0]            add_sum,
  input  logic                   add_underflow,
  input  logic                   add_overflow,
  input  logic                   add_inexact,
  output logic [15:0]            issue_count
);

  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0] r_busy;
  logic [NUM_REQ-1:0] r_resp_valid;
  logic [IDW-1:0]     r_ptr;
  logic [15:0]        r_issue_count;
  logic [LAT-1:0]     r_tag_vld;
  logic [IDW-1:0]     r_tag_id [LAT];
  logic [18:0]        r_buf [NUM_REQ];

  logic [NUM_REQ-1:0] w_elig;
  logic [NUM_REQ-1:0] w_gnt_oh;
  logic               w_gnt_vld;
  logic [IDW-1:0]     w_gnt_id;
  logic [IDW-1:0]     w_scan_idx;
  logic [IDW-1:0]     w_ptr_nxt;
  logic [15:0]        w_opa;
  logic [15:0]        w_opb;
  logic               w_cap_vld;
  logic [IDW-1:0]     w_cap_id;
  logic [NUM_REQ-1:0] w_resp_hs;

  assign w_elig    = req_valid & ~r_busy;
  assign w_resp_hs = r_resp_valid & resp_ready;
  assign w_cap_vld = r_tag_vld[LAT-1];
  assign w_cap_id  = r_tag_id[LAT-1];

  // Round-robin search from r_ptr upward; scanning downward lets the nearest hit win.
  always_comb begin
    w_gnt_vld  = 1'b0;
    w_gnt_id   = '0;
    w_scan_idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      w_scan_idx = IDW'((int'(r_ptr) + k) % NUM_REQ);
      w_gnt_vld  = w_elig[w_scan_idx] ? 1'b1 : w_gnt_vld;
      w_gnt_id   = w_elig[w_scan_idx] ? w_scan_idx : w_gnt_id;
    end
  end

  // One-hot grant vector and operand mux toward the adder.
  always_comb begin
    w_gnt_oh = '0;
    w_opa    = 16'h0000;
    w_opb    = 16'h0000;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_gnt_oh[i] = w_gnt_vld && (w_gnt_id == IDW'(i));
      w_opa       = w_opa | (w_gnt_oh[i] ? req_opA[16*i +: 16] : 16'h0000);
      w_opb       = w_opb | (w_gnt_oh[i] ? req_opB[16*i +: 16] : 16'h0000);
    end
  end

  assign w_ptr_nxt = (w_gnt_id == IDW'(NUM_REQ - 1)) ? '0 : (w_gnt_id + IDW'(1));

  assign req_ready   = w_gnt_oh;
  assign add_issue   = w_gnt_vld;
  assign add_opA     = w_opa;
  assign add_opB     = w_opb;
  assign resp_valid  = r_resp_valid;
  assign issue_count = r_issue_count;

  // Outstanding-op flags: set on accept, cleared when the response is consumed.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_busy <= '0;
    end else begin
      r_busy <= (r_busy | (w_gnt_oh & req_valid)) & ~w_resp_hs;
    end
  end

  // Priority pointer and wrapping issue counter advance only on a grant.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ptr         <= '0;
      r_issue_count <= 16'h0000;
    end else if (w_gnt_vld) begin
      r_ptr         <= w_ptr_nxt;
      r_issue_count <= r_issue_count + 16'd1;
    end else begin
      r_ptr         <= r_ptr;
      r_issue_count <= r_issue_count;
    end
  end

  // Tag pipeline mirrors the adder latency so each result finds its owner.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tag_vld <= '0;
      for (int s = 0; s < LAT; s++) begin
        r_tag_id[s] <= '0;
      end
    end else begin
      r_tag_vld[0] <= w_gnt_vld;
      r_tag_id[0]  <= w_gnt_id;
      for (int s = 1; s < LAT; s++) begin
        r_tag_vld[s] <= r_tag_vld[s-1];
        r_tag_id[s]  <= r_tag_id[s-1];
      end
    end
  end

  // Result buffers; busy gating rules out a write and a consume on the same entry.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_resp_valid <= '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        r_buf[i] <= 19'h00000;
      end
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (w_cap_vld && (w_cap_id == IDW'(i))) begin
          r_buf[i]        <= {add_underflow, add_overflow, add_inexact, add_sum};
          r_resp_valid[i] <= 1'b1;
        end else if (w_resp_hs[i]) begin
          r_buf[i]        <= r_buf[i];
          r_resp_valid[i] <= 1'b0;
        end else begin
          r_buf[i]        <= r_buf[i];
          r_resp_valid[i] <= r_resp_valid[i];
        end
      end
    end
  end

  // Flatten the buffers onto the response bus.
  always_comb begin
    resp_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      resp_data[19*i +: 19] = r_buf[i];
    end
  end

endmodule
